// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution scheduler slice.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    // Width of a counter able to hold 0..maxk.
    function automatic int k_bits(input int maxk);
        return $clog2(maxk + 1);
    endfunction

    // Width of an address into an r x c input image.
    function automatic int xa_bits(input int r, input int c);
        return $clog2(r * c);
    endfunction

    // Width of an address into a maxk x maxk kernel.
    function automatic int wa_bits(input int maxk);
        return $clog2(maxk * maxk);
    endfunction

    // Width of a credit counter able to hold 0..depth.
    function automatic int cr_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/conv_credit_ctr.sv
// Output FIFO credit counter: starts full, one credit per reserved pixel,
// one credit returned per FIFO pop.
module conv_credit_ctr
    import conv_pkg::*;
#(
    parameter int DEPTH = 7,
    localparam int CR_W = cr_bits(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            take,
    input  logic            give,
    output logic [CR_W-1:0] credits
);

    // A take and a give in the same cycle cancel, so the count only moves on one of them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= CR_W'(DEPTH);
        end else if (take && !give) begin
            credits <= credits - CR_W'(1);
        end else if (give && !take) begin
            credits <= credits + CR_W'(1);
        end
    end

    // Catch a reservation with no credit left, or a pop while the FIFO is already empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(take && !give && credits == '0));
            assert (!(give && credits == CR_W'(DEPTH)));
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Sequencer for the 2D convolution datapath: walks output pixels and kernel
// taps, drives MAC beats, and pushes finished pixels into the output FIFO.
module conv_sched
    import conv_pkg::*;
#(
    parameter int R          = 8,
    parameter int C          = 8,
    parameter int MAXK       = 5,
    parameter int MAC_LAT    = 4,
    parameter int FIFO_DEPTH = 7,
    localparam int K_BITS    = k_bits(MAXK),
    localparam int XA_W      = xa_bits(R, C),
    localparam int WA_W      = wa_bits(MAXK),
    localparam int CR_W      = cr_bits(FIFO_DEPTH),
    localparam int PC_W      = $clog2(R * C + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inputs_loaded,
    input  logic [K_BITS-1:0] K,
    input  logic              fifo_pop,
    output logic [XA_W-1:0]   x_addr,
    output logic [WA_W-1:0]   w_addr,
    output logic              mac_valid,
    output logic              mac_init,
    output logic              fifo_push,
    output logic              compute_finished,
    output logic              busy
);

    sched_state_t       state, next_state;
    logic [K_BITS-1:0]  k_reg, i, j;
    logic [XA_W-1:0]    r, c;
    logic [PC_W-1:0]    pix_issued, push_count;
    logic [CR_W-1:0]    credits;
    logic [MAC_LAT-1:0] lat_sr;
    logic               loaded_q, mac_last_q;
    logic               start, tap0, beat, reserve;
    logic               j_last, i_last, c_last, r_last, tap_last;
    logic [XA_W-1:0]    row_sum, col_sum, x_next;
    logic [WA_W-1:0]    w_next;

    conv_credit_ctr #(
        .DEPTH (FIFO_DEPTH)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .take    (reserve),
        .give    (fifo_pop),
        .credits (credits)
    );

    // Loop bounds, beat issue decision, next addresses and the next FSM state.
    always_comb begin
        start      = inputs_loaded && !loaded_q;
        tap0       = (i == '0) && (j == '0);
        j_last     = (j == k_reg - K_BITS'(1));
        i_last     = (i == k_reg - K_BITS'(1));
        c_last     = (c == XA_W'(C) - XA_W'(k_reg));
        r_last     = (r == XA_W'(R) - XA_W'(k_reg));
        tap_last   = i_last && j_last;
        beat       = (state == ISSUE) && !(tap0 && credits == '0);
        reserve    = beat && tap0;
        row_sum    = r + XA_W'(i);
        col_sum    = c + XA_W'(j);
        x_next     = XA_W'(row_sum * XA_W'(C)) + col_sum;
        w_next     = WA_W'(WA_W'(i) * WA_W'(k_reg)) + WA_W'(j);
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ISSUE;
            ISSUE:   if (beat && tap_last && c_last && r_last) next_state = DRAIN;
            DRAIN:   if (push_count == pix_issued && credits == CR_W'(FIFO_DEPTH)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Tap/pixel counters, registered MAC beat outputs and push bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            loaded_q   <= 1'b0;
            k_reg      <= '0;
            r          <= '0;
            c          <= '0;
            i          <= '0;
            j          <= '0;
            pix_issued <= '0;
            push_count <= '0;
            x_addr     <= '0;
            w_addr     <= '0;
            mac_valid  <= 1'b0;
            mac_init   <= 1'b0;
            mac_last_q <= 1'b0;
        end else begin
            loaded_q   <= inputs_loaded;
            mac_valid  <= beat;
            mac_init   <= beat && tap0;
            mac_last_q <= beat && tap_last;
            if (beat) begin
                x_addr <= x_next;
                w_addr <= w_next;
            end
            if (fifo_push) begin
                push_count <= push_count + PC_W'(1);
            end
            if (state == IDLE && start) begin
                k_reg      <= K;
                r          <= '0;
                c          <= '0;
                i          <= '0;
                j          <= '0;
                pix_issued <= '0;
                push_count <= '0;
            end else if (beat) begin
                if (reserve) begin
                    pix_issued <= pix_issued + PC_W'(1);
                end
                if (j_last) begin
                    j <= '0;
                    if (i_last) begin
                        i <= '0;
                        if (c_last) begin
                            c <= '0;
                            r <= r + XA_W'(1);
                        end else begin
                            c <= c + XA_W'(1);
                        end
                    end else begin
                        i <= i + K_BITS'(1);
                    end
                end else begin
                    j <= j + K_BITS'(1);
                end
            end
        end
    end

    // Delay the last-tap flag by the MAC latency so it lines up with the finished result.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_sr <= '0;
        end else begin
            lat_sr <= (lat_sr << 1) | MAC_LAT'(mac_valid && mac_last_q);
        end
    end

    assign fifo_push        = lat_sr[MAC_LAT-1];
    assign compute_finished = (state == DONE);
    assign busy             = (state != IDLE);

endmodule
